// File: rtl/uart_pkg.sv
// Shared UART definitions for the tx/rx pair.
// Stop-length encoding, rx state enum and data width.
package uart_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] STOP_0P5 = 2'b00;
  localparam logic [1:0] STOP_1   = 2'b01;
  localparam logic [1:0] STOP_1P5 = 2'b10;
  localparam logic [1:0] STOP_2   = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  // Half stop is sampled at 3/4 of a bit after the bit-7 sample.
  function automatic logic [15:0] stop_point(
    input logic [1:0]  sb,
    input logic [15:0] b
  );
    stop_point = (sb == STOP_0P5) ? (b >> 1) + (b >> 2) : b;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for one asynchronous input.
// Resets to 1 so an idle-high line shows no edge out of reset.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= '1;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, programmable stop length.
// Pulses data_valid on a good stop sample, frame_error on a low one.
module uart_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic [15:0] bit_duration,
  input  logic [1:0]  stopbits,
  output logic [7:0]  data,
  output logic        data_valid,
  output logic        frame_error,
  output logic        busy
);

  rx_state_e         state_q, state_n;
  logic [15:0]       ctr_q, ctr_n;
  logic [2:0]        bidx_q, bidx_n;
  logic [DATA_W-1:0] shift_q, shift_n;
  logic [DATA_W-1:0] data_q;
  logic [15:0]       b_q;
  logic [1:0]        sb_q;
  logic              rxs, rxs_d;
  logic              dv_q, dv_n;
  logic              fe_q, fe_n;
  logic              latch, load;
  logic [15:0]       h;
  logic [15:0]       sp;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rxs)
  );

  assign h  = b_q >> 1;
  assign sp = stop_point(sb_q, b_q);

  always_comb begin
    state_n = state_q;
    ctr_n   = ctr_q + 16'd1;
    bidx_n  = bidx_q;
    shift_n = shift_q;
    dv_n    = 1'b0;
    fe_n    = 1'b0;
    latch   = 1'b0;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        ctr_n = '0;
        if (rxs_d && !rxs) begin
          state_n = START;
          latch   = 1'b1;
        end
      end
      START: begin
        if (ctr_q == h) begin
          ctr_n   = '0;
          bidx_n  = '0;
          state_n = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (ctr_q == b_q) begin
          ctr_n   = '0;
          shift_n = {rxs, shift_q[DATA_W-1:1]};
          if (bidx_q == 3'(DATA_W - 1)) begin
            state_n = STOP;
          end else begin
            bidx_n = bidx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (ctr_q == sp) begin
          ctr_n = '0;
          if (rxs) begin
            dv_n    = 1'b1;
            load    = 1'b1;
            state_n = IDLE;
          end else begin
            fe_n    = 1'b1;
            state_n = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        ctr_n = '0;
        // A held-low break must not look like a fresh start edge.
        if (rxs) begin
          state_n = IDLE;
        end
      end
      default: begin
        ctr_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      bidx_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      b_q     <= '0;
      sb_q    <= '0;
      rxs_d   <= 1'b1;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      ctr_q   <= ctr_n;
      bidx_q  <= bidx_n;
      shift_q <= shift_n;
      rxs_d   <= rxs;
      dv_q    <= dv_n;
      fe_q    <= fe_n;
      if (latch) begin
        b_q  <= bit_duration;
        sb_q <= stopbits;
      end
      if (load) begin
        data_q <= shift_q;
      end
    end
  end

  assign data        = data_q;
  assign data_valid  = dv_q;
  assign frame_error = fe_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of the team's UART transmitter.
- Deserialises 8N framed bytes (start bit, 8 data bits LSB first, programmable stop length) from an asynchronous rx pin.
- Uses the same bit_duration / stopbits run-time configuration as the transmitter, so a tx/rx pair shares one config register.
- Presents each received byte with a one-cycle valid pulse and flags framing errors.

Parameters:
- SYNC_STAGES, 2, number of flops in the rx input synchroniser (legal range 2..4).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- rx  input  1  asynchronous serial input; idle high
- bit_duration  input  16  bit period minus one, in clk cycles (one bit = bit_duration+1 clocks); must be >= 3
- stopbits  input  2  stop length: 00=0.5, 01=1, 10=1.5, 11=2 bits
- data  output  8  last correctly received byte
- data_valid  output  1  one-cycle pulse when data is updated
- frame_error  output  1  one-cycle pulse when the stop sample is low
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: data=0, data_valid=0, frame_error=0, busy=0, all synchroniser flops=1, state=IDLE, counters=0.
- Reset is honoured in any state, including mid-frame. The next cycle is IDLE with no pulse emitted.
- The synchroniser output is called rxs. All timing below is relative to rxs; the SYNC_STAGES pipeline delay is accepted and not compensated.
- On entry to START, bit_duration and stopbits are latched into internal registers. Input changes during a frame are ignored.
- Notation: B = latched bit_duration, H = B>>1, Q = B>>2. The sample counter ctr is 16 bits, resets to 0 on every state change and on every sample, and never wraps within a legal frame.
- IDLE:
  - busy=0.
  - A falling edge on rxs (previous 1, current 0) moves to START with ctr=0.
  - A constant low level does not trigger START; only an edge does.
- START:
  - When ctr==H (mid start bit), sample rxs.
  - rxs=1: false start, go to IDLE with no pulse.
  - rxs=0: go to DATA with bit index 0.
- DATA:
  - When ctr==B, sample rxs into shift bit[index], LSB first.
  - On index 7, go to STOP; otherwise increment index.
- STOP:
  - Stop sample point, counted from the bit-7 sample:
    - stopbits=00: ctr==H+Q (middle of a half stop bit)
    - stopbits=01, 10, 11: ctr==B (middle of the first stop bit)
  - At the sample point with rxs=1: data<=shift register, data_valid=1 for exactly the next cycle, go to IDLE. Any additional stop time is plain idle-high line and is not checked.
  - At the sample point with rxs=0: frame_error=1 for exactly one cycle, data unchanged, go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay until rxs==1, then go to IDLE.
  - This prevents a break condition (line held low) from retriggering start detection.
- Pulse rules:
  - data_valid and frame_error are never high together.
  - Each pulse lasts exactly one cycle.
  - data holds its value between valid pulses.
- Back-to-back frames: the rx side returns to IDLE before the transmitter's stop time ends for every stopbits setting, so a start edge immediately after the minimum stop time is detected.

Decomposition:
- uart_pkg, shared with the transmitter, holds:
  - stopbit encoding constants (STOP_0P5, STOP_1, STOP_1P5, STOP_2)
  - the rx state enum (IDLE, START, DATA, STOP, WAIT_IDLE)
  - the data width constant (8)
- One sub-module, sync_bit: a SYNC_STAGES-deep synchroniser with reset value 1, reusable for other async inputs.
- The FSM, counter and shift register stay in uart_rx.

Test Plan:
- Loopback: uart_tx to uart_rx, bit_duration=15, stopbits=01, send 0xA5 -> exactly one data_valid pulse, data=0xA5, frame_error never asserted.
- Back-to-back: send 0x00, 0xFF, 0x3C with stopbits=00 and data_ready held, bit_duration=15 -> three valid pulses in order with the correct bytes, no errors.
- False start: rx low for 4 clocks then high, bit_duration=15 -> returns to IDLE, no data_valid, no frame_error, busy drops within H+SYNC_STAGES+2 cycles.
- Framing error: a frame of 0x55 with rx held low through the stop bit and 40 more clocks -> one frame_error pulse, data keeps its previous value, busy stays high until rx goes high, then a following 0x12 frame is received correctly.
- Reset mid-frame: assert rst for 1 cycle during DATA bit 3 -> outputs return to reset values, no pulse; the next full frame 0x81 is received correctly.
- Config latch: change bit_duration from 15 to 7 during DATA bit 2 -> the current byte is still received correctly at the old rate, and the next frame is received at the new rate.
